// File: rtl/load_return_unit.sv
// Load return path: queues load metadata, pairs in-order memory returns,
// extracts/extends the addressed byte/half. Optional LOAD_ALIGN_CHECK_EN flags misalignment.
module load_return_unit #(
  parameter int DEPTH = 2,
  parameter int CNT_W = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_addr_low,
  input  logic [2:0]  req_type,
  input  logic        req_signed,
  input  logic        mem_rvalid,
  output logic        mem_rready,
  input  logic [31:0] mem_rdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  output logic        busy
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [2:0] T_BYTE = 3'd0;
  localparam logic [2:0] T_HALF = 3'd1;

  typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [CNT_W-1:0]   drop_q, drop_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [31:0]        rsp_data_q, rsp_data_d;
  logic               rsp_err_q, rsp_err_d;

  logic [1:0]         addr_q [DEPTH];
  logic [2:0]         type_q [DEPTH];
  logic               sgn_q  [DEPTH];

  logic        push, pop, drain, mem_fire, drop_ret;
  logic [1:0]  hd_addr;
  logic [2:0]  hd_type;
  logic        hd_sgn;
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic [31:0] ext;
  logic        mis;

  assign drain      = (state_q == DRAIN);
  assign req_ready  = (count_q < CNT_W'(DEPTH)) & ~flush;
  assign mem_rready = drain |
                      ((count_q != '0) & (~rsp_valid_q | rsp_ready));
  assign push       = req_valid & req_ready;
  assign mem_fire   = mem_rvalid & mem_rready;
  assign pop        = mem_fire & ~drain;
  assign drop_ret   = mem_fire & drain;

  assign hd_addr = addr_q[rd_ptr_q];
  assign hd_type = type_q[rd_ptr_q];
  assign hd_sgn  = sgn_q[rd_ptr_q];

  always_comb begin
    byte_v = mem_rdata[7:0];
    unique case (hd_addr)
      2'd0: byte_v = mem_rdata[7:0];
      2'd1: byte_v = mem_rdata[15:8];
      2'd2: byte_v = mem_rdata[23:16];
      2'd3: byte_v = mem_rdata[31:24];
    endcase
    half_v = hd_addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    ext = mem_rdata;
    unique case (hd_type)
      T_BYTE:  ext = {{24{hd_sgn & byte_v[7]}}, byte_v};
      T_HALF:  ext = {{16{hd_sgn & half_v[15]}}, half_v};
      default: ext = mem_rdata;
    endcase
`ifdef LOAD_ALIGN_CHECK_EN
    unique case (hd_type)
      T_BYTE:  mis = 1'b0;
      T_HALF:  mis = hd_addr[0];
      default: mis = (hd_addr != 2'd0);
    endcase
    if (mis) ext = '0;
`else
    mis = 1'b0;
`endif
  end

  always_comb begin
    count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    // a return accepted in the flush cycle is discarded, not counted as pending
    drop_d   = drop_q - CNT_W'(drop_ret) +
               (flush ? (count_q - CNT_W'(pop)) : '0);
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    state_d     = state_q;
    if (flush) begin
      count_d     = '0;
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      rsp_valid_d = 1'b0;
      state_d     = (drop_d != '0) ? DRAIN : IDLE;
    end else begin
      if (pop) begin
        rsp_valid_d = 1'b1;
        rsp_data_d  = ext;
        rsp_err_d   = mis;
      end else if (rsp_ready) begin
        rsp_valid_d = 1'b0;
      end
      unique case (state_q)
        IDLE:    state_d = push ? ACTIVE : IDLE;
        ACTIVE:  state_d = (count_d == '0) ? IDLE : ACTIVE;
        DRAIN:   state_d = (drop_d != '0) ? DRAIN :
                           (count_d != '0) ? ACTIVE : IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      count_q     <= '0;
      drop_q      <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        type_q[i] <= '0;
        sgn_q[i]  <= 1'b0;
      end
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      drop_q      <= drop_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      if (push) begin
        addr_q[wr_ptr_q] <= req_addr_low;
        type_q[wr_ptr_q] <= req_type;
        sgn_q[wr_ptr_q]  <= req_signed;
      end
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign busy      = (count_q != '0) | (drop_q != '0) | rsp_valid_q;

endmodule
